// File: rtl/acc_datapath_multicycle.sv
// rtl/acc_datapath_multicycle.sv - multicycle accumulator CPU core with req/ack data-memory handshake
// Defining ACC_DP_IMM_EN turns opcode E into LDI (AC = zero-extended operand); otherwise E is a NOP.
module acc_datapath_multicycle #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int OPCODE_W = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         run,
   output logic [ADDR_W-1:0]            instMemAddrBus,
   input  logic [OPCODE_W+ADDR_W-1:0]   instMemDataBus,
   output logic [ADDR_W-1:0]            dataMemAddrBus,
   output logic [DATA_W-1:0]            dataMemInDataBus,
   input  logic [DATA_W-1:0]            dataMemOutDataBus,
   output logic                         dm_req,
   output logic                         dm_we,
   input  logic                         dm_ack,
   output logic [DATA_W-1:0]            acOut,
   output logic [DATA_W-1:0]            aluOut,
   output logic                         zero_flag,
   output logic                         carry_flag,
   output logic                         halted
);
   typedef logic [OPCODE_W-1:0] op_t;
   localparam op_t OP_LDA = op_t'(1);
   localparam op_t OP_STA = op_t'(2);
   localparam op_t OP_ADD = op_t'(3);
   localparam op_t OP_SUB = op_t'(4);
   localparam op_t OP_AND = op_t'(5);
   localparam op_t OP_OR  = op_t'(6);
   localparam op_t OP_XOR = op_t'(7);
   localparam op_t OP_NOT = op_t'(8);
   localparam op_t OP_JMP = op_t'(9);
   localparam op_t OP_JZ  = op_t'(10);
   localparam op_t OP_JC  = op_t'(11);
   localparam op_t OP_SHL = op_t'(12);
   localparam op_t OP_SHR = op_t'(13);
`ifdef ACC_DP_IMM_EN
   localparam op_t OP_LDI = op_t'(14);
`endif
   localparam op_t OP_HLT = op_t'(15);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT} state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            pc_q, pc_d;
   logic [DATA_W-1:0]            ac_q, ac_d;
   logic [DATA_W-1:0]            mdr_q, mdr_d;
   logic [OPCODE_W+ADDR_W-1:0]   ir_q, ir_d;
   logic                         z_q, z_d, c_q, c_d;

   op_t                          opcode;
   logic [ADDR_W-1:0]            operand;
   logic                         is_mem_op, take_branch;
   logic [DATA_W-1:0]            alu_res;
   logic                         alu_carry, alu_wr_ac, alu_wr_c;

   assign opcode      = ir_q[OPCODE_W+ADDR_W-1:ADDR_W];
   assign operand     = ir_q[ADDR_W-1:0];
   assign is_mem_op   = (opcode != op_t'(0)) && (opcode <= OP_XOR);
   assign take_branch = (opcode == OP_JMP) || ((opcode == OP_JZ) && z_q) || ((opcode == OP_JC) && c_q);

   // Non-ALU opcodes pass AC through so aluOut stays stable between instructions.
   always_comb begin
      alu_res   = ac_q;
      alu_carry = c_q;
      alu_wr_ac = 1'b0;
      alu_wr_c  = 1'b0;
      case (opcode)
         OP_LDA: begin alu_res = mdr_q; alu_wr_ac = 1'b1; end
         OP_ADD: begin {alu_carry, alu_res} = {1'b0, ac_q} + {1'b0, mdr_q}; alu_wr_ac = 1'b1; alu_wr_c = 1'b1; end
         OP_SUB: begin {alu_carry, alu_res} = {1'b0, ac_q} - {1'b0, mdr_q}; alu_wr_ac = 1'b1; alu_wr_c = 1'b1; end
         OP_AND: begin alu_res = ac_q & mdr_q; alu_wr_ac = 1'b1; end
         OP_OR:  begin alu_res = ac_q | mdr_q; alu_wr_ac = 1'b1; end
         OP_XOR: begin alu_res = ac_q ^ mdr_q; alu_wr_ac = 1'b1; end
         OP_NOT: begin alu_res = ~ac_q; alu_wr_ac = 1'b1; end
         OP_SHL: begin alu_res = ac_q << 1; alu_carry = ac_q[DATA_W-1]; alu_wr_ac = 1'b1; alu_wr_c = 1'b1; end
         OP_SHR: begin alu_res = ac_q >> 1; alu_carry = ac_q[0]; alu_wr_ac = 1'b1; alu_wr_c = 1'b1; end
`ifdef ACC_DP_IMM_EN
         OP_LDI: begin alu_res = DATA_W'(operand); alu_wr_ac = 1'b1; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ac_d    = ac_q;
      mdr_d   = mdr_q;
      ir_d    = ir_q;
      z_d     = z_q;
      c_d     = c_q;
      case (state_q)
         S_FETCH: begin
            if (run) begin
               ir_d    = instMemDataBus;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode == OP_HLT)  state_d = S_HALT;
            else if (is_mem_op)    state_d = S_MEM;
            else                   state_d = S_EXEC;
         end
         S_MEM: begin
            if (dm_ack) begin
               if (opcode != OP_STA) mdr_d = dataMemOutDataBus;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (alu_wr_ac) begin
               ac_d = alu_res;
               z_d  = (alu_res == '0);
            end
            if (alu_wr_c) c_d = alu_carry;
            pc_d    = take_branch ? operand : pc_q + ADDR_W'(1);
            state_d = S_FETCH;
         end
         S_HALT:  ;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ac_q    <= '0;
         mdr_q   <= '0;
         ir_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ac_q    <= ac_d;
         mdr_q   <= mdr_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign instMemAddrBus   = pc_q;
   assign dataMemAddrBus   = operand;
   assign dataMemInDataBus = ac_q;
   assign dm_req           = (state_q == S_MEM);
   assign dm_we            = dm_req && (opcode == OP_STA);
   assign acOut            = ac_q;
   assign aluOut           = alu_res;
   assign zero_flag        = z_q;
   assign carry_flag       = c_q;
   assign halted           = (state_q == S_HALT);
endmodule

// File: doc/acc_datapath_multicycle.md
Name: acc_datapath_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle accumulator datapath.
- Integrates PC, instruction register, accumulator, ALU, Z/C flags and a control FSM.
- Adds a req/ack handshake to data memory, conditional branches, shifts and halt.
- Sits between instruction ROM and data RAM as the complete accumulator CPU core.

Parameters:
- DATA_W, 8, accumulator/ALU/data bus width
- ADDR_W, 4, PC and data-address width; PC wraps modulo 2^ADDR_W
- OPCODE_W, 4, opcode field width; instruction width IW = OPCODE_W+ADDR_W

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- run  in  1  1 = FSM may leave FETCH
- instMemAddrBus  out  ADDR_W  PC value
- instMemDataBus  in  IW  instruction; opcode = [IW-1:ADDR_W], operand = [ADDR_W-1:0]
- dataMemAddrBus  out  ADDR_W  IR operand field
- dataMemInDataBus  out  DATA_W  accumulator value (store data)
- dataMemOutDataBus  in  DATA_W  load data
- dm_req  out  1  data-memory request
- dm_we  out  1  1 = write; valid only while dm_req=1
- dm_ack  in  1  memory completes the request this cycle
- acOut  out  DATA_W  accumulator
- aluOut  out  DATA_W  combinational ALU result of AC op MDR
- zero_flag  out  1  Z
- carry_flag  out  1  C
- halted  out  1  core is in HALT

Behaviour:
- Reset (sync, at the clock edge): PC=0, AC=0, IR=0, MDR=0, Z=0, C=0, state=FETCH, dm_req=0, halted=0. A reset during MEM abandons the request: dm_req=0 from the cycle after the reset edge, and any late dm_ack is ignored.
- Opcodes:
  - 0 NOP
  - 1 LDA: AC=mem
  - 2 STA: mem=AC
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR with mem
  - 8 NOT: AC=~AC
  - 9 JMP
  - A JZ
  - B JC
  - C SHL
  - D SHR (logical)
  - E reserved
  - F HLT
  - Memory opcodes: 1-7.
- FSM states:
  - FETCH: if run=1, IR<=instMemDataBus, go DECODE; else hold.
  - DECODE: HLT -> HALT; memory opcode -> MEM; else -> EXEC.
  - MEM: dm_req=1 (combinational from state); dm_we=1 only for STA. Address and data are held stable. On dm_ack, MDR<=dataMemOutDataBus (loads), go EXEC; otherwise stay in MEM. An ack in the same cycle as the request is legal.
  - EXEC: update AC/flags/PC, go FETCH.
  - HALT: halted=1, PC/AC/flags frozen; exit only via reset.
- Latency: non-memory instruction = 3 cycles; memory instruction = 3 + cycles spent in MEM (minimum 4).
- PC update (EXEC): target = operand for JMP, JZ when Z=1, JC when C=1; otherwise PC+1. PC wraps 2^ADDR_W-1 -> 0.
- Arithmetic/flags, all DATA_W bits, results truncated:
  - ADD: C = carry-out.
  - SUB: AC-MDR, C = borrow (AC<MDR unsigned).
  - SHL: C = shifted-out MSB.
  - SHR: C = shifted-out LSB.
  - AND/OR/XOR/NOT/LDA: C unchanged.
  - Z = (new AC==0) on every AC write; STA/NOP/jumps leave both flags unchanged.
- dm_ack outside MEM is ignored. run=0 only takes effect in FETCH; an in-flight instruction always completes.
- aluOut is combinational from AC, MDR and IR opcode; it is undefined-but-stable for non-ALU opcodes (drive AC).

Optional Feature:
- Macro ACC_DP_IMM_EN.
- Defined: opcode E = LDI, AC = zero-extended operand field, Z updated, C unchanged, no memory access, 3 cycles.
- Undefined: opcode E behaves as NOP.

Test Plan:
- Reset held 2 cycles mid-MEM -> PC=0, AC=0, Z=C=0, dm_req=0 next cycle, halted=0; a stray dm_ack afterwards causes no state change.
- mem[3]=0x7F, mem[4]=0x81; program LDA 3, ADD 4 with ack delayed 2 cycles -> AC=0x00, Z=1, C=1; each instruction takes 6 cycles; dm_we=0 throughout.
- AC=0x5A, STA 9 -> dm_req=1, dm_we=1, dataMemAddrBus=9, dataMemInDataBus=0x5A held until ack; AC and flags unchanged.
- JZ 0xC with Z=1 -> PC=0xC; with Z=0 -> PC+1; NOP at PC=0xF -> PC wraps to 0x0.
- SUB mem=0x01 from AC=0x00 -> AC=0xFF, C=1, Z=0; SHR of 0x01 -> AC=0x00, C=1, Z=1.
- HLT -> halted=1 the cycle after DECODE, PC frozen, run toggling has no effect; run=0 in FETCH stalls indefinitely; with ACC_DP_IMM_EN, opcode E operand 0x7 -> AC=0x07 in 3 cycles.
